// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak loader modes, FSM states, rates, domain bytes and rate helpers
package keccak_pkg;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'b00,
        MODE_SHA3_512 = 2'b01,
        MODE_SHAKE128 = 2'b10,
        MODE_SHAKE256 = 2'b11
    } load_mode_t;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_LOAD,
        ST_PAD
    } load_state_t;

    localparam int RATE_SHA3_256 = 1088;
    localparam int RATE_SHA3_512 = 576;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

    function automatic logic [10:0] rate_bits(input load_mode_t mode);
        logic [10:0] r;
        case (mode)
            MODE_SHA3_512: r = 11'(RATE_SHA3_512);
            MODE_SHAKE128: r = 11'(RATE_SHAKE128);
            MODE_SHAKE256: r = 11'(RATE_SHAKE256);
            default:       r = 11'(RATE_SHA3_256);
        endcase
        return r;
    endfunction

    function automatic logic [5:0] rate_words(input load_mode_t mode, input int w);
        return 6'(int'(rate_bits(mode)) / w);
    endfunction

    function automatic logic [7:0] domain_byte(input load_mode_t mode);
        return (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) ? DOMAIN_SHAKE : DOMAIN_SHA3;
    endfunction

endpackage

// File: rtl/multirate_block_buf.sv
// rtl/multirate_block_buf.sv - one rate-sized block register with mode/size/last sideband
module multirate_block_buf
    import keccak_pkg::*;
#(
    parameter int W        = 64,
    parameter int MAX_RATE = RATE_SHAKE128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [5:0]          wr_idx,
    input  logic [W-1:0]        wr_data,
    input  logic                close_en,
    input  logic                pad_en,
    input  logic [7:0]          pad_pos,
    input  logic [7:0]          pad_end,
    input  logic [7:0]          pad_dom,
    input  logic [1:0]          mode,
    input  logic [31:0]         osize,
    input  logic                free_en,
    output logic [MAX_RATE-1:0] block,
    output logic [1:0]          block_mode,
    output logic [31:0]         block_osize,
    output logic                block_last,
    output logic                full
);

    logic [MAX_RATE-1:0] block_n;

    // Blocking updates so the domain and 0x80 bytes merge when they coincide.
    always_comb begin
        block_n = block;
        if (wr_en) block_n[int'(wr_idx)*W +: W] = wr_data;
        if (pad_en) begin
            block_n[int'(pad_pos)*8 +: 8] = block_n[int'(pad_pos)*8 +: 8] | pad_dom;
            block_n[int'(pad_end)*8 +: 8] = block_n[int'(pad_end)*8 +: 8] | 8'h80;
        end
    end

    // Clearing on free keeps bytes past the written words zero for the next block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block       <= '0;
            block_mode  <= 2'b00;
            block_osize <= 32'd0;
            block_last  <= 1'b0;
            full        <= 1'b0;
        end else if (free_en) begin
            block       <= '0;
            block_mode  <= 2'b00;
            block_osize <= 32'd0;
            block_last  <= 1'b0;
            full        <= 1'b0;
        end else begin
            block <= block_n;
            if (close_en || pad_en) begin
                full        <= 1'b1;
                block_last  <= pad_en;
                block_mode  <= mode;
                block_osize <= osize;
            end
        end
    end

endmodule

// File: rtl/multirate_load_stage.sv
// rtl/multirate_load_stage.sv - Keccak multi-mode header/data loader; LOAD_DOUBLE_BUFFER_EN selects ping-pong buffers
module multirate_load_stage
    import keccak_pkg::*;
#(
    parameter int W        = 64,
    parameter int MAX_RATE = RATE_SHAKE128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        data_i,
    input  logic                valid_i,
    output logic                ready_i,
    output logic [MAX_RATE-1:0] rate_input,
    output logic                block_valid,
    input  logic                block_ready,
    output logic                block_last,
    output logic [1:0]          operation_mode,
    output logic [31:0]         output_size
);

    localparam int WB = W / 8;

    load_state_t         state, state_n;
    load_mode_t          mode_q;
    logic [31:0]         osize_q, bytes_left, take;
    logic [5:0]          word_idx;
    logic [7:0]          pad_pos, pad_end, pad_dom;
    logic [W-1:0]        wr_data;
    logic                accept, last_word, blk_end, wr_en, close_en, pad_en, hs;
    logic                fill_full, out_full, out_last;
    logic [MAX_RATE-1:0] out_block;
    logic [1:0]          out_mode;
    logic [31:0]         out_osize;

    assign ready_i   = !rst && !fill_full && (state != ST_PAD);
    assign accept    = valid_i && ready_i;
    assign take      = (bytes_left < 32'(WB)) ? bytes_left : 32'(WB);
    assign last_word = (bytes_left <= 32'(WB));
    assign blk_end   = (word_idx == rate_words(mode_q, W) - 6'd1);
    assign pad_end   = 8'(rate_bits(mode_q) >> 3) - 8'd1;
    assign pad_dom   = domain_byte(mode_q);
    assign hs        = block_valid && block_ready;

    always_comb begin
        wr_data = '0;
        for (int b = 0; b < WB; b++)
            if (32'(b) < bytes_left) wr_data[8*b +: 8] = data_i[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_HDR0;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        close_en = 1'b0;
        pad_en   = 1'b0;
        case (state)
            ST_HDR0: if (accept) state_n = ST_HDR1;
            ST_HDR1: if (accept) state_n = ST_HDR2;
            ST_HDR2: if (accept) state_n = (data_i[31:0] != 32'd0) ? ST_LOAD : ST_PAD;
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        // Only a completely data-filled block closes here; a short tail is padded in place.
                        close_en = blk_end && (bytes_left == 32'(WB));
                        state_n  = ST_PAD;
                    end else begin
                        close_en = blk_end;
                    end
                end
            end
            ST_PAD: begin
                if (!fill_full) begin
                    pad_en  = 1'b1;
                    state_n = ST_HDR0;
                end
            end
            default: state_n = ST_HDR0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_SHA3_256;
            osize_q    <= 32'd0;
            bytes_left <= 32'd0;
            word_idx   <= 6'd0;
            pad_pos    <= 8'd0;
        end else begin
            if (accept && state == ST_HDR0) mode_q <= load_mode_t'(data_i[1:0]);
            if (accept && state == ST_HDR1) osize_q <= data_i[31:0];
            if (accept && state == ST_HDR2) begin
                bytes_left <= data_i[31:0];
                pad_pos    <= 8'd0;
                word_idx   <= 6'd0;
            end
            if (wr_en) begin
                bytes_left <= bytes_left - take;
                pad_pos    <= close_en ? 8'd0 : 8'(32'(word_idx) * 32'(WB) + take);
                word_idx   <= close_en ? 6'd0 : word_idx + 6'd1;
            end
            if (pad_en) word_idx <= 6'd0;
        end
    end

`ifdef LOAD_DOUBLE_BUFFER_EN
    logic                fill_sel, out_sel;
    logic [1:0]          full_v, last_v;
    logic [MAX_RATE-1:0] block_v [2];
    logic [1:0]          mode_v  [2];
    logic [31:0]         osize_v [2];

    for (genvar g = 0; g < 2; g++) begin : g_buf
        multirate_block_buf #(.W(W), .MAX_RATE(MAX_RATE)) u_buf (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en && fill_sel == 1'(g)),
            .wr_idx     (word_idx),
            .wr_data    (wr_data),
            .close_en   (close_en && fill_sel == 1'(g)),
            .pad_en     (pad_en && fill_sel == 1'(g)),
            .pad_pos    (pad_pos),
            .pad_end    (pad_end),
            .pad_dom    (pad_dom),
            .mode       (mode_q),
            .osize      (osize_q),
            .free_en    (hs && out_sel == 1'(g)),
            .block      (block_v[g]),
            .block_mode (mode_v[g]),
            .block_osize(osize_v[g]),
            .block_last (last_v[g]),
            .full       (full_v[g])
        );
    end

    assign fill_full = full_v[fill_sel];
    assign out_full  = full_v[out_sel];
    assign out_last  = last_v[out_sel];
    assign out_block = block_v[out_sel];
    assign out_mode  = mode_v[out_sel];
    assign out_osize = osize_v[out_sel];

    // Both pointers advance strictly alternately, so blocks leave in fill order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_sel <= 1'b0;
            out_sel  <= 1'b0;
        end else begin
            if (close_en || pad_en) fill_sel <= ~fill_sel;
            if (hs)                 out_sel  <= ~out_sel;
        end
    end
`else
    multirate_block_buf #(.W(W), .MAX_RATE(MAX_RATE)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (word_idx),
        .wr_data    (wr_data),
        .close_en   (close_en),
        .pad_en     (pad_en),
        .pad_pos    (pad_pos),
        .pad_end    (pad_end),
        .pad_dom    (pad_dom),
        .mode       (mode_q),
        .osize      (osize_q),
        .free_en    (hs),
        .block      (out_block),
        .block_mode (out_mode),
        .block_osize(out_osize),
        .block_last (out_last),
        .full       (out_full)
    );

    assign fill_full = out_full;
`endif

    // A partially filled buffer is never visible downstream.
    assign block_valid    = out_full;
    assign block_last     = out_full && out_last;
    assign rate_input     = out_full ? out_block : '0;
    assign operation_mode = out_full ? out_mode : 2'b00;
    assign output_size    = out_full ? out_osize : 32'd0;

endmodule

// File: tb/tb_multirate_load_stage.sv
// tb/tb_multirate_load_stage.sv - randomized scoreboard bench for multirate_load_stage
module tb_multirate_load_stage;

    typedef logic [1343:0] chk_t;
    typedef struct {
        chk_t        blk;
        logic        last;
        logic [1:0]  mode;
        logic [31:0] osize;
    } exp_t;

`ifdef LOAD_DOUBLE_BUFFER_EN
    localparam int BP_ACC = 42;
`else
    localparam int BP_ACC = 21;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_i;
    logic [1343:0] rate_input;
    logic          block_valid;
    logic          block_ready;
    logic          block_last;
    logic [1:0]    operation_mode;
    logic [31:0]   output_size;

    int   total = 0;
    int   bad = 0;
    int   ncnt = 0;
    int   last_acc_n = 0;
    int   nrx = 0;
    bit   rx_hold = 1'b0;
    exp_t exp_q[$];
    int   rise_q[$];
    chk_t last_rx_blk = '0;
    logic last_rx_last = 1'b0;
    logic [1:0] last_rx_mode = 2'b00;

    multirate_load_stage #(.W(64), .MAX_RATE(1344)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_i       (ready_i),
        .rate_input    (rate_input),
        .block_valid   (block_valid),
        .block_ready   (block_ready),
        .block_last    (block_last),
        .operation_mode(operation_mode),
        .output_size   (output_size)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncnt <= ncnt + 1;

    task automatic chk(input string tag, input chk_t got, input chk_t exp);
        total++;
        if (got !== exp) begin
            int lane = 0;
            bad++;
            for (int i = 20; i >= 0; i--) if (got[64*i +: 64] !== exp[64*i +: 64]) lane = i;
            $display("FAIL %s lane=%0d got=%h exp=%h", tag, lane, got[64*lane +: 64], exp[64*lane +: 64]);
        end
    endtask

    function automatic int rbytes(input logic [1:0] mode);
        case (mode)
            2'b00:   return 136;
            2'b01:   return 72;
            2'b10:   return 168;
            default: return 136;
        endcase
    endfunction

    // Reference: flatten message bytes, apply pad10*1 over whole rate blocks, then slice.
    task automatic push_expected(input logic [1:0] mode, input int len, input logic [31:0] osize,
                                 input logic [63:0] words[$]);
        int rb = rbytes(mode);
        int nblk = len / rb + 1;
        logic [7:0] m[];
        logic [63:0] w;
        exp_t e;
        m = new[nblk * rb];
        foreach (m[i]) m[i] = 8'h00;
        for (int i = 0; i < len; i++) begin
            w = words[i / 8];
            m[i] = w[8*(i % 8) +: 8];
        end
        m[len] = m[len] | (mode[1] ? 8'h1F : 8'h06);
        m[nblk*rb - 1] = m[nblk*rb - 1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int k = 0; k < rb; k++) e.blk[8*k +: 8] = m[b*rb + k];
            e.last  = (b == nblk - 1);
            e.mode  = mode;
            e.osize = osize;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [63:0] d);
        int n = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_i) begin
            if (n == 4000) begin
                chk("send_timeout", chk_t'(0), chk_t'(1));
                valid_i = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        last_acc_n = ncnt;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] mode, input int len, input logic [31:0] osize,
                            input bit rnd, input logic [63:0] fill, input bit gaps);
        logic [63:0] words[$];
        logic [63:0] h;
        for (int i = 0; i < (len + 7) / 8; i++) words.push_back(rnd ? {$urandom, $urandom} : fill);
        push_expected(mode, len, osize, words);
        h = {$urandom, $urandom};
        h[1:0] = mode;
        send_word(h);
        send_word({$urandom, osize});
        send_word({$urandom, 32'(len)});
        foreach (words[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(words[i]);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || block_valid) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", chk_t'(exp_q.size()), chk_t'(0));
    endtask

    task automatic chk_rise(input string tag, input int lat);
        chk(tag, chk_t'(rise_q.size() != 0 ? rise_q[0] - last_acc_n : -1), chk_t'(lat));
    endtask

    // Receiver: random backpressure, stability of stalled blocks, in-order scoreboard.
    initial begin
        bit   prev_v = 1'b0;
        chk_t prev_blk = '0;
        exp_t e;
        block_ready = 1'b0;
        forever begin
            @(negedge clk);
            block_ready = rx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rst) begin
                prev_v = 1'b0;
                continue;
            end
            if (prev_v) begin
                chk("stall_valid", chk_t'(block_valid), chk_t'(1));
                chk("stall_data", rate_input, prev_blk);
            end
            if (block_valid && !prev_v) rise_q.push_back(ncnt);
            if (block_valid && block_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_block", chk_t'(1), chk_t'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_data", rate_input, e.blk);
                    chk("blk_last", chk_t'(block_last), chk_t'(e.last));
                    chk("blk_mode", chk_t'(operation_mode), chk_t'(e.mode));
                    chk("blk_osize", chk_t'(output_size), chk_t'(e.osize));
                end
                last_rx_blk  = rate_input;
                last_rx_last = block_last;
                last_rx_mode = operation_mode;
                nrx++;
                prev_v = 1'b0;
            end else begin
                prev_v   = block_valid;
                prev_blk = rate_input;
            end
        end
    end

    initial begin
        logic [63:0] bpw[$];
        logic [63:0] h;
        int acc, idle, nrx0, mode, len, rb;

        repeat (3) @(negedge clk);
        chk("rst_ready", chk_t'(ready_i), chk_t'(0));
        chk("rst_valid", chk_t'(block_valid), chk_t'(0));
        chk("rst_last", chk_t'(block_last), chk_t'(0));
        chk("rst_data", rate_input, chk_t'(0));
        chk("rst_mode", chk_t'(operation_mode), chk_t'(0));
        chk("rst_osize", chk_t'(output_size), chk_t'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", chk_t'(ready_i), chk_t'(1));

        // SHAKE128 empty message
        rise_q.delete();
        send_msg(2'b10, 0, 32'd256, 1'b0, 64'd0, 1'b0);
        wait_drain();
        chk_rise("len0_latency", 2);
        chk("len0_b0", chk_t'(last_rx_blk[7:0]), chk_t'(8'h1F));
        chk("len0_b167", chk_t'(last_rx_blk[8*167 +: 8]), chk_t'(8'h80));
        chk("len0_last", chk_t'(last_rx_last), chk_t'(1));
        chk("len0_mode", chk_t'(last_rx_mode), chk_t'(2'b10));

        // SHA3-256, domain and end marker share byte 135
        rise_q.delete();
        send_msg(2'b00, 135, 32'd256, 1'b0, {8{8'hAA}}, 1'b0);
        wait_drain();
        chk_rise("len135_latency", 2);
        chk("len135_b134", chk_t'(last_rx_blk[8*134 +: 8]), chk_t'(8'hAA));
        chk("len135_b135", chk_t'(last_rx_blk[8*135 +: 8]), chk_t'(8'h86));

        // SHAKE256, data ends exactly at the block boundary
        rise_q.delete();
        nrx0 = nrx;
        send_msg(2'b11, 136, 32'd512, 1'b1, 64'd0, 1'b0);
        wait_drain();
        chk_rise("len136_first_latency", 1);
        chk("len136_nblk", chk_t'(nrx - nrx0), chk_t'(2));
        chk("len136_b0", chk_t'(last_rx_blk[7:0]), chk_t'(8'h1F));
        chk("len136_b135", chk_t'(last_rx_blk[8*135 +: 8]), chk_t'(8'h80));

        // SHA3-512 short tail: bytes beyond len must be zeroed
        send_msg(2'b01, 5, 32'd512, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_drain();
        chk("len5_b4", chk_t'(last_rx_blk[8*4 +: 8]), chk_t'(8'hFF));
        chk("len5_b5", chk_t'(last_rx_blk[8*5 +: 8]), chk_t'(8'h06));
        chk("len5_b6", chk_t'(last_rx_blk[8*6 +: 8]), chk_t'(8'h00));
        chk("len5_b71", chk_t'(last_rx_blk[8*71 +: 8]), chk_t'(8'h80));

        // SHAKE128 len=336 with downstream stalled
        for (int i = 0; i < 42; i++) bpw.push_back({$urandom, $urandom});
        push_expected(2'b10, 336, 32'd1000, bpw);
        rx_hold = 1'b1;
        send_word(64'h2);
        send_word(64'd1000);
        send_word(64'd336);
        acc = 0;
        idle = 0;
        valid_i = 1'b1;
        data_i = bpw[0];
        while (idle < 30 && acc < 42) begin
            if (ready_i) begin
                acc++;
                idle = 0;
                @(negedge clk);
                if (acc < 42) data_i = bpw[acc];
            end else begin
                idle++;
                @(negedge clk);
            end
        end
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_accepted", chk_t'(acc), chk_t'(BP_ACC));
        chk("bp_ready_low", chk_t'(ready_i), chk_t'(0));
        chk("bp_valid", chk_t'(block_valid), chk_t'(1));
        chk("bp_last", chk_t'(block_last), chk_t'(0));
        rx_hold = 1'b0;
        for (int i = acc; i < 42; i++) send_word(bpw[i]);
        wait_drain();

        // Abort mid-message with reset
        h = 64'h0;
        send_word(h);
        send_word(64'd256);
        send_word(64'd200);
        for (int i = 0; i < 10; i++) send_word({$urandom, $urandom});
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_ready", chk_t'(ready_i), chk_t'(0));
        chk("abort_valid", chk_t'(block_valid), chk_t'(0));
        chk("abort_data", rate_input, chk_t'(0));
        chk("abort_osize", chk_t'(output_size), chk_t'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rel_ready", chk_t'(ready_i), chk_t'(1));
        send_msg(2'b00, 0, 32'd256, 1'b0, 64'd0, 1'b0);
        wait_drain();
        chk("abort_next_b0", chk_t'(last_rx_blk[7:0]), chk_t'(8'h06));
        chk("abort_next_b135", chk_t'(last_rx_blk[8*135 +: 8]), chk_t'(8'h80));

        // Randomized messages concentrated around block boundaries
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            rb = rbytes(2'(mode));
            case ($urandom_range(0, 4))
                0:       len = rb - 1;
                1:       len = rb;
                2:       len = rb + 1;
                3:       len = 2 * rb;
                default: len = int'($urandom_range(0, 350));
            endcase
            send_msg(2'(mode), len, $urandom, 1'b1, 64'd0, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
